// File: rtl/dsp_sequencer_if.sv
// Sequencer-side bus bundle: frame control in, instruction RAM port,
// core instruction bus and frame status out.
interface dsp_sequencer_if #(
  parameter int INSTR_WIDTH     = 26,
  parameter int PROG_ADDR_WIDTH = 10,
  parameter int FRAME_CNT_WIDTH = 16
);
  logic                       sample_tick;
  logic                       run_en;
  logic [PROG_ADDR_WIDTH:0]   prog_len;
  logic                       clear_overrun;
  logic [PROG_ADDR_WIDTH-1:0] imem_rd_addr;
  logic [INSTR_WIDTH-1:0]     imem_rd_data;
  logic [INSTR_WIDTH-1:0]     instruction;
  logic                       busy;
  logic                       frame_done;
  logic                       overrun_pulse;
  logic                       overrun_flag;
  logic [FRAME_CNT_WIDTH-1:0] frame_count;

  modport master (
    output sample_tick, run_en, prog_len,
    output clear_overrun, imem_rd_data,
    input  imem_rd_addr, instruction, busy,
    input  frame_done, overrun_pulse,
    input  overrun_flag, frame_count
  );

  modport slave (
    input  sample_tick, run_en, prog_len,
    input  clear_overrun, imem_rd_data,
    output imem_rd_addr, instruction, busy,
    output frame_done, overrun_pulse,
    output overrun_flag, frame_count
  );
endinterface

// File: rtl/dsp_sequencer.sv
// Per-sample program sequencer: replays prog_len instructions from imem
// onto the dsp_core instruction bus each sample_tick, then drains the core.
module dsp_sequencer #(
  parameter int INSTR_WIDTH     = 26,
  parameter int PROG_ADDR_WIDTH = 10,
  parameter int PIPELINE_DEPTH  = 4,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  dsp_sequencer_if.slave   io
);
  localparam int LW = PROG_ADDR_WIDTH + 1;
  localparam int DW = (PIPELINE_DEPTH > 0) ?
                      $clog2(PIPELINE_DEPTH + 1) : 1;
  localparam logic [LW-1:0] MAX_LEN =
    {1'b1, {PROG_ADDR_WIDTH{1'b0}}};
  localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPELINE_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [LW-1:0]              pc_q, pc_d;
  logic [LW-1:0]              len_q, len_d;
  logic [LW-1:0]              len_clamp;
  logic [DW-1:0]              drain_q, drain_d;
  logic                       valid_q, fetch_valid;
  logic                       done_q, done_d;
  logic                       ovr_q, ovr_d;
  logic                       flag_q, flag_d;
  logic [FRAME_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                       accept;

  assign len_clamp = (io.prog_len > MAX_LEN) ?
                     MAX_LEN : io.prog_len;
  assign accept = (state_q == IDLE) &
                  io.sample_tick & io.run_en;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    len_d       = len_q;
    drain_d     = drain_q;
    done_d      = 1'b0;
    cnt_d       = cnt_q;
    fetch_valid = 1'b0;
    // Ticks while busy are dropped, only flagged.
    ovr_d  = io.sample_tick & io.run_en &
             (state_q != IDLE);
    flag_d = ovr_d | (flag_q & ~io.clear_overrun);
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          pc_d  = '0;
          len_d = len_clamp;
          if (len_clamp == '0) begin
            done_d = 1'b1;
            cnt_d  = cnt_q + FRAME_CNT_WIDTH'(1);
          end else begin
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        fetch_valid = 1'b1;
        pc_d        = pc_q + LW'(1);
        if (pc_q == len_q - LW'(1)) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cnt_d   = cnt_q + FRAME_CNT_WIDTH'(1);
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      drain_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      drain_q <= drain_d;
      valid_q <= fetch_valid;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
    end
  end

  // valid_q tracks the one-cycle RAM read latency.
  assign io.imem_rd_addr  = (state_q == FETCH) ?
                            pc_q[PROG_ADDR_WIDTH-1:0] : '0;
  assign io.instruction   = valid_q ? io.imem_rd_data :
                            {INSTR_WIDTH{1'b0}};
  assign io.busy          = (state_q != IDLE);
  assign io.frame_done    = done_q;
  assign io.overrun_pulse = ovr_q;
  assign io.overrun_flag  = flag_q;
  assign io.frame_count   = cnt_q;
endmodule

// File: tb/tb_dsp_sequencer.sv
// Random and directed stimulus for dsp_sequencer against a
// cycle-timeline reference model of frames, overruns and counts.
module tb_dsp_sequencer;
  logic clk = 1'b0;
  logic reset_n;

  dsp_sequencer_if sif();

  dsp_sequencer u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (sif)
  );

  always #5 clk = ~clk;

  logic [25:0] mem [1024];

  always @(posedge clk)
    sif.imem_rd_data <= mem[sif.imem_rd_addr];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  bit act;
  int st, ln, done_at, ov_at, cnt_e;
  bit flag_e;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    act     = 1'b0;
    st      = 0;
    ln      = 0;
    done_at = -1;
    ov_at   = -1;
    cnt_e   = 0;
    flag_e  = 1'b0;
  endtask

  task automatic model_check();
    bit          b_e;
    int          a_e;
    logic [25:0] i_e;
    if (cyc == done_at) begin
      cnt_e++;
      act = 1'b0;
    end
    b_e = act && cyc > st && cyc < done_at;
    a_e = 0;
    if (act && cyc >= st + 1 && cyc <= st + ln)
      a_e = cyc - st - 1;
    i_e = '0;
    if (act && cyc >= st + 2 && cyc <= st + ln + 1)
      i_e = mem[cyc - st - 2];
    chk("busy",  32'(sif.busy),          32'(b_e));
    chk("addr",  32'(sif.imem_rd_addr),  32'(a_e));
    chk("instr", 32'(sif.instruction),   32'(i_e));
    chk("done",  32'(sif.frame_done),    32'(cyc == done_at));
    chk("ovp",   32'(sif.overrun_pulse), 32'(cyc == ov_at));
    chk("ovf",   32'(sif.overrun_flag),  32'(flag_e));
    chk("fcnt",  32'(sif.frame_count),   32'(cnt_e[15:0]));
  endtask

  task automatic model_update(input bit tk, input bit re,
                              input int pl, input bit clr);
    bit busy_now, ovr;
    int n;
    busy_now = act && cyc > st && cyc < done_at;
    ovr = tk && re && busy_now;
    if (ovr) begin
      ov_at = cyc + 1;
    end else if (tk && re) begin
      n = (pl > 1024) ? 1024 : pl;
      if (n == 0) begin
        done_at = cyc + 1;
      end else begin
        act     = 1'b1;
        st      = cyc;
        ln      = n;
        done_at = cyc + n + 6;
      end
    end
    flag_e = ovr ? 1'b1 : (clr ? 1'b0 : flag_e);
  endtask

  task automatic step(input bit tk, input bit re,
                      input int pl, input bit clr);
    @(posedge clk);
    cyc++;
    #1;
    sif.sample_tick   = tk;
    sif.run_en        = re;
    sif.prog_len      = 11'(pl);
    sif.clear_overrun = clr;
    @(negedge clk);
    model_check();
    model_update(tk, re, pl, clr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 0, 1'b0);
  endtask

  task automatic reset_now();
    @(posedge clk);
    cyc++;
    #1;
    reset_n           = 1'b0;
    sif.sample_tick   = 1'b0;
    sif.clear_overrun = 1'b0;
    #1;
    chk("rst_instr", 32'(sif.instruction),  32'd0);
    chk("rst_busy",  32'(sif.busy),         32'd0);
    chk("rst_addr",  32'(sif.imem_rd_addr), 32'd0);
    chk("rst_ovf",   32'(sif.overrun_flag), 32'd0);
    chk("rst_fcnt",  32'(sif.frame_count),  32'd0);
    model_reset();
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    #1 reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 26'($urandom);
    model_reset();
    reset_n           = 1'b0;
    sif.sample_tick   = 1'b0;
    sif.run_en        = 1'b0;
    sif.prog_len      = '0;
    sif.clear_overrun = 1'b0;
    #12;
    chk("init_instr", 32'(sif.instruction),   32'd0);
    chk("init_busy",  32'(sif.busy),          32'd0);
    chk("init_done",  32'(sif.frame_done),    32'd0);
    chk("init_ovp",   32'(sif.overrun_pulse), 32'd0);
    chk("init_ovf",   32'(sif.overrun_flag),  32'd0);
    chk("init_fcnt",  32'(sif.frame_count),   32'd0);
    reset_n = 1'b1;
    idle(3);

    // three-instruction frame
    step(1'b1, 1'b1, 3, 1'b0);
    idle(12);

    // overrun at +5, accepted re-tick at +9
    step(1'b1, 1'b1, 3, 1'b0);
    idle(4);
    step(1'b1, 1'b1, 3, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 3, 1'b0);
    idle(12);

    // tick exactly on the DRAIN->IDLE cycle
    step(1'b1, 1'b1, 2, 1'b0);
    idle(6);
    step(1'b1, 1'b1, 2, 1'b0);
    idle(6);

    // empty program
    step(1'b1, 1'b1, 0, 1'b0);
    idle(3);

    // full-size and clamped programs
    step(1'b1, 1'b1, 1024, 1'b0);
    idle(1035);
    step(1'b1, 1'b1, 2000, 1'b0);
    idle(1035);

    // reset in cycle 3 of a ten-instruction frame
    step(1'b1, 1'b1, 10, 1'b0);
    idle(2);
    reset_now();
    idle(2);
    step(1'b1, 1'b1, 10, 1'b0);
    idle(20);

    // run_en low: no frame, no overrun
    step(1'b1, 1'b0, 5, 1'b0);
    idle(3);

    // clear coinciding with a fresh overrun
    step(1'b1, 1'b1, 5, 1'b0);
    step(1'b1, 1'b1, 5, 1'b0);
    idle(1);
    step(1'b1, 1'b1, 5, 1'b1);
    idle(1);
    step(1'b0, 1'b1, 0, 1'b1);
    idle(12);

    for (int i = 0; i < 3000; i++) begin
      bit tk, re, clr;
      int pl;
      tk  = ($urandom_range(0, 9) == 0);
      re  = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 15) == 0);
      pl  = ($urandom_range(0, 99) < 2) ?
            int'($urandom_range(1000, 2047)) :
            int'($urandom_range(0, 12));
      step(tk, re, pl, clr);
    end
    idle(1040);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
